l1_tag_lookup_ctrl: RTL
=======================

Name: l1_tag_lookup_ctrl

Overview:
- Tag lookup and refill controller for the 2-way L1 cache.
- Sits directly upstream of the two synchronous-read tag RAMs (way 0, way 1). It drives their shared address and write ports and consumes their registered-address read data.
- Accepts one CPU request at a time and returns hit or miss plus the selected way. On a miss it requests a line refill, writes the new tag into the victim way, and maintains a per-set LRU bit.

Parameters:
- AWIDTH, 3, set index width; must match the tag RAM AWIDTH; sets = 1<<AWIDTH.
- TWIDTH, 15, tag width; tag RAM word width = TWIDTH+1 (bit TWIDTH is the valid bit, bits TWIDTH-1:0 are the tag).
- OWIDTH, 4, line offset width.
- CWIDTH, 16, width of the hit and miss statistic counters.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  controller can accept a request
- req_addr  in  TWIDTH+AWIDTH+OWIDTH  byte address, split as {tag, index, offset}
- resp_valid  out  1  response valid
- resp_ready  in  1  CPU accepts the response
- resp_hit  out  1  1 = hit, 0 = miss that has been refilled
- resp_way  out  1  way that holds the line
- refill_valid  out  1  refill request to the next level
- refill_addr  out  TWIDTH+AWIDTH+OWIDTH  line-aligned refill address {tag, index, 0}
- refill_ack  in  1  single-cycle refill-complete pulse
- tag_addr  out  AWIDTH  shared address to both tag RAMs
- tag_din  out  TWIDTH+1  shared write data to both tag RAMs
- tag_we0  out  1  write enable, way-0 tag RAM
- tag_we1  out  1  write enable, way-1 tag RAM
- tag_dout0  in  TWIDTH+1  way-0 tag RAM read data
- tag_dout1  in  TWIDTH+1  way-1 tag RAM read data
- hit_count  out  CWIDTH  saturating hit counter
- miss_count  out  CWIDTH  saturating miss counter

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - tag_idx_q, idx_q, lru[] and both counters clear to 0.
  - All outputs read 0, except req_ready=1 once reset_n=1.
  - tag_we0/tag_we1 drop to 0 immediately, including mid-FILL.
  - Tag RAM contents are untouched.
- States: IDLE, LOOKUP, COMPARE, REFILL, FILL, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge: register tag_q and idx_q, then go to LOOKUP.
- tag_addr = idx_q in every state. The RAMs latch it at the LOOKUP→COMPARE edge, so tag_dout0/1 are valid throughout COMPARE.
- COMPARE (combinational, one cycle):
  - hitN = tag_doutN[TWIDTH] & (tag_doutN[TWIDTH-1:0]==tag_q).
  - If both ways hit, way 0 wins.
  - On hit: resp_hit_q=1, resp_way_q=hit way, lru[idx_q]=~hit way, hit_count+1, go to RESP.
  - On miss:
    - Pick the victim: way 0 if it is invalid; else way 1 if it is invalid; else lru[idx_q].
    - Register the victim and miss_count+1, then go to REFILL.
- REFILL:
  - refill_valid=1, refill_addr={tag_q, idx_q, OWIDTH'b0}, held stable.
  - On refill_ack go to FILL.
  - refill_ack outside REFILL is ignored.
- FILL (one cycle):
  - tag_din={1'b1, tag_q}; assert only the victim's tag_weN.
  - lru[idx_q]=~victim; resp_hit_q=0, resp_way_q=victim; go to RESP.
- RESP:
  - resp_valid=1; resp_hit and resp_way held.
  - On resp_ready go to IDLE. A new request can be accepted only in the following cycle (req_ready=0 outside IDLE).
- Hit latency: accept edge E0, COMPARE after E1, resp_valid high after E2.
- Miss latency: from refill_ack, FILL lasts one cycle, then RESP.
- A lookup that immediately follows a FILL to the same index sees the new tag (the RAM write lands at the FILL edge).
- Counters saturate at all-ones and do not wrap.
- resp_valid, refill_valid and tag_we* are registered-state decodes and are glitch-free.

Test Plan:
- Preload set 2 with way0={1,0x0123} and way1 invalid. Request tag 0x0123, idx 2 → resp_valid on the 2nd edge after accept, resp_hit=1, resp_way=0, lru[2]=1, hit_count=1.
- Start from cold (all invalid). Request tag 0x0456, idx 5 → refill_valid with refill_addr={0x0456,5,0}. Ack 3 cycles later → FILL writes tag_we0=1 with tag_din=0x8456 → resp_hit=0, resp_way=0. Repeat the request → hit on way 0.
- Set 1 holds way0=0x0AAA and way1=0x0BBB, both valid, with the last access to way 0. A miss on 0x0CCC → victim is way 1, tag_we1 pulses, lru[1]=0.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid and resp_way stay stable and req_ready=0. Req_valid asserted during this window is not accepted until the cycle after resp_ready.
- Assert reset_n=0 during REFILL, then during FILL → refill_valid and tag_we* drop to 0 at once, state returns to IDLE, counters read 0. An ack pulse arriving after reset is ignored.
- Preload miss_count to 0xFFFE via repeated misses → the next two misses leave it at 0xFFFF.

Source files
------------

// File: rtl/l1_tag_lookup_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | l1_tag_lookup_ctrl : 2-way L1 tag lookup / refill controller with LRU      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module l1_tag_lookup_ctrl #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 15,
  parameter int OWIDTH = 4,
  parameter int CWIDTH = 16
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [TWIDTH+AWIDTH+OWIDTH-1:0]  req_addr,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic                             resp_hit,
  output logic                             resp_way,
  output logic                             refill_valid,
  output logic [TWIDTH+AWIDTH+OWIDTH-1:0]  refill_addr,
  input  logic                             refill_ack,
  output logic [AWIDTH-1:0]                tag_addr,
  output logic [TWIDTH:0]                  tag_din,
  output logic                             tag_we0,
  output logic                             tag_we1,
  input  logic [TWIDTH:0]                  tag_dout0,
  input  logic [TWIDTH:0]                  tag_dout1,
  output logic [CWIDTH-1:0]                hit_count,
  output logic [CWIDTH-1:0]                miss_count
);

  localparam int SETS    = 1 << AWIDTH;
  localparam int RAWIDTH = TWIDTH + AWIDTH + OWIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_COMPARE = 3'd2,
    S_REFILL  = 3'd3,
    S_FILL    = 3'd4,
    S_RESP    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [TWIDTH-1:0]   tag_q, tag_d;
  logic [AWIDTH-1:0]   idx_q, idx_d;
  logic                victim_q, victim_d;
  logic                resp_hit_q, resp_hit_d;
  logic                resp_way_q, resp_way_d;
  logic [SETS-1:0]     lru_q, lru_d;
  logic [CWIDTH-1:0]   hit_count_q, hit_count_d;
  logic [CWIDTH-1:0]   miss_count_q, miss_count_d;

  logic w_hit0, w_hit1;
  logic w_unused_offset;

  assign w_hit0 = tag_dout0[TWIDTH] && (tag_dout0[TWIDTH-1:0] == tag_q);
  assign w_hit1 = tag_dout1[TWIDTH] && (tag_dout1[TWIDTH-1:0] == tag_q);
  assign w_unused_offset = ^req_addr[OWIDTH-1:0];

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    victim_d     = victim_q;
    resp_hit_d   = resp_hit_q;
    resp_way_d   = resp_way_q;
    lru_d        = lru_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          tag_d   = req_addr[RAWIDTH-1 -: TWIDTH];
          idx_d   = req_addr[OWIDTH +: AWIDTH];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_COMPARE;
      S_COMPARE: begin
        if (w_hit0 || w_hit1) begin
          // Way 0 takes priority when both ways match.
          resp_hit_d   = 1'b1;
          resp_way_d   = ~w_hit0;
          lru_d[idx_q] = w_hit0;
          if (hit_count_q != {CWIDTH{1'b1}})
            hit_count_d = hit_count_q + CWIDTH'(1);
          state_d = S_RESP;
        end else begin
          if (!tag_dout0[TWIDTH])      victim_d = 1'b0;
          else if (!tag_dout1[TWIDTH]) victim_d = 1'b1;
          else                         victim_d = lru_q[idx_q];
          if (miss_count_q != {CWIDTH{1'b1}})
            miss_count_d = miss_count_q + CWIDTH'(1);
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (refill_ack) state_d = S_FILL;
      end
      S_FILL: begin
        lru_d[idx_q] = ~victim_q;
        resp_hit_d   = 1'b0;
        resp_way_d   = victim_q;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      victim_q     <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= 1'b0;
      lru_q        <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      victim_q     <= victim_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      lru_q        <= lru_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // All strobes decode the registered state only, so they cannot glitch.
  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_RESP);
  assign resp_hit     = resp_hit_q;
  assign resp_way     = resp_way_q;
  assign refill_valid = (state_q == S_REFILL);
  assign refill_addr  = (state_q == S_REFILL) ? {tag_q, idx_q, {OWIDTH{1'b0}}} : '0;
  assign tag_addr     = idx_q;
  assign tag_din      = (state_q == S_FILL) ? {1'b1, tag_q} : '0;
  assign tag_we0      = (state_q == S_FILL) && !victim_q;
  assign tag_we1      = (state_q == S_FILL) &&  victim_q;
  assign hit_count    = hit_count_q;
  assign miss_count   = miss_count_q;

endmodule
`default_nettype wire
